sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 The module SHALL have parameter MEM_AW, default 14, meaning the RAM word-address width (RAM depth 2^MEM_AW words of 32 bits).
REQ-002 The module SHALL have parameter MMIO_BASE, default 32'h1FAF_0000, meaning the physical base of the 64 KB MMIO window.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 inst_sram_en  input  1  instruction-port request valid.
REQ-006 inst_sram_wen  input  4  instruction-port byte write enables; must be zero.
REQ-007 inst_sram_addr  input  32  instruction-port byte address.
REQ-008 inst_sram_wdata  input  32  instruction-port write data; ignored.
REQ-009 inst_sram_rdata  output  32  instruction read data.
REQ-010 data_sram_en  input  1  data-port request valid.
REQ-011 data_sram_wen  input  4  data-port byte write enables; bit i covers wdata[8i+7:8i].
REQ-012 data_sram_addr  input  32  data-port byte address.
REQ-013 data_sram_wdata  input  32  data-port write data.
REQ-014 data_sram_rdata  output  32  data read data.
REQ-015 led  output  16  LED register contents.
REQ-016 switch  input  8  asynchronous switch inputs.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 Physical address SHALL be addr & 32'h1FFF_FFFF; addr[1:0] SHALL be ignored (word access only).
REQ-019 A physical address in [MMIO_BASE, MMIO_BASE+16'hFFFF] SHALL select MMIO; any other address SHALL select RAM word phys[MEM_AW+1:2] (aliasing, never out of range).
REQ-020 Read latency SHALL be exactly one cycle: request in cycle N -> rdata valid in cycle N+1, with no stall or handshake.
REQ-021 When a port's en is low in cycle N, its rdata SHALL hold its previous value in cycle N+1.
REQ-022 Data-port writes SHALL update only the bytes whose wen bit is set; wen=4'h0 with en=1 is a read.
REQ-023 A data-port write returns, in cycle N+1, data_sram_rdata equal to the pre-write word (read-first).
REQ-024 An instruction read and a data write to the same RAM word in the same cycle SHALL return the pre-write word on inst_sram_rdata; a read of that word in cycle N+1 SHALL return the new word.
REQ-025 The instruction port SHALL never write; inst_sram_en=1 with inst_sram_wen!=0 SHALL perform a read only and set err.
REQ-026 The instruction port SHALL return 32'h0 for MMIO addresses and set err.
REQ-027 MMIO offsets (phys[15:0]): 0x0 LED RW (bits 15:0, upper read 0); 0x4 SWITCH RO (bits 7:0, upper read 0); 0x8 TIMER RW 32-bit; 0xC SCRATCH RW 32-bit.
REQ-028 Data access to any other MMIO offset SHALL read 32'h0, drop writes, and set err; writes to SWITCH SHALL be dropped without err.
REQ-029 switch SHALL pass through a two-flop synchronizer; SWITCH reads return the second-stage value.
REQ-030 TIMER SHALL increment by 1 (mod 2^32, wrapping 32'hFFFF_FFFF -> 0) every cycle not written; a write loads the byte-merged value instead of incrementing.
REQ-031 MMIO reads SHALL return the register value at the request cycle, before that cycle's write or increment.
REQ-032 err SHALL remain 1 from the setting cycle until reset.

Reset
REQ-033 While rst=1: inst_sram_rdata=0, data_sram_rdata=0, led=0, TIMER=0, SCRATCH=0, synchronizer=0, err=0; requests SHALL be ignored (no writes).
REQ-034 RAM contents SHALL not be reset; reset asserted mid-operation SHALL cancel that cycle's write.
REQ-035 TIMER SHALL read 0 for a request in the first cycle after rst deasserts, then 1, 2, ...

Verification
REQ-036 Data write 0xBFC00010 wen=4'hF wdata=0x12345678, then inst read 0x1FC00010 -> inst_sram_rdata=0x12345678 (kseg alias).
REQ-037 Word=0xAABBCCDD; write wen=4'b0101 wdata=0x11223344 -> next read 0xAA22CC44.
REQ-038 Same-cycle inst read and data write of 0x0 to a word holding 0x5 -> inst_sram_rdata=0x5; re-read next cycle -> 0x0.
REQ-039 Write TIMER=0xFFFFFFFE, read TIMER in each of next 3 cycles -> 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
REQ-040 switch=0xA5 set; SWITCH read two cycles later -> 0xA5; then data read of MMIO offset 0x10 -> rdata=0, err=1 held until rst.

Source files
------------

// File: rtl/sram_responder.sv
// Single-cycle SRAM responder with an instruction read port, a data read/write port
// and a small MMIO window (LED, SWITCH, TIMER, SCRATCH).
`timescale 1ns/1ps
module sram_responder #(
    parameter int          MEM_AW    = 14,
    parameter logic [31:0] MMIO_BASE = 32'h1FAF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch,
    output logic        err
);

    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [13:0] {
        REG_LED     = 14'd0,
        REG_SWITCH  = 14'd1,
        REG_TIMER   = 14'd2,
        REG_SCRATCH = 14'd3
    } mmio_reg_e;

    function automatic logic in_mmio(input logic [31:0] phys);
        return ({1'b0, phys} >= {1'b0, MMIO_BASE}) &&
               ({1'b0, phys} <= ({1'b0, MMIO_BASE} + 33'h0_FFFF));
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  wen);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++)
            if (wen[b]) merged[8*b +: 8] = new_val[8*b +: 8];
        return merged;
    endfunction

    logic [31:0] r_mem [0:DEPTH-1];
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;
    logic [15:0] r_led;
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;
    logic [31:0] r_timer;
    logic [31:0] r_scratch;
    logic        r_err;

    logic [31:0]     w_i_phys;
    logic [31:0]     w_d_phys;
    logic            w_i_mmio;
    logic            w_d_mmio;
    logic [MEM_AW-1:0] w_i_idx;
    logic [MEM_AW-1:0] w_d_idx;
    mmio_reg_e       w_d_reg;
    logic            w_d_wr;
    logic            w_d_mmio_acc;
    logic            w_d_bad;
    logic            w_i_bad;
    logic [31:0]     w_led_merged;
    logic [31:0]     w_mmio_rdata;
    logic            w_unused_wdata;

    assign w_i_phys     = inst_sram_addr & 32'h1FFF_FFFF;
    assign w_d_phys     = data_sram_addr & 32'h1FFF_FFFF;
    assign w_i_mmio     = in_mmio(w_i_phys);
    assign w_d_mmio     = in_mmio(w_d_phys);
    assign w_i_idx      = w_i_phys[MEM_AW+1:2];
    assign w_d_idx      = w_d_phys[MEM_AW+1:2];
    assign w_d_reg      = mmio_reg_e'(w_d_phys[15:2]);
    assign w_d_wr       = data_sram_wen != 4'h0;
    assign w_d_mmio_acc = data_sram_en && w_d_mmio;
    assign w_d_bad      = w_d_mmio_acc && (w_d_phys[15:2] > 14'd3);
    assign w_i_bad      = inst_sram_en && ((inst_sram_wen != 4'h0) || w_i_mmio);
    assign w_led_merged = byte_merge({16'h0, r_led}, data_sram_wdata, data_sram_wen);
    // The instruction port is read-only; its write data has no destination.
    assign w_unused_wdata = ^inst_sram_wdata;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        w_mmio_rdata = 32'h0;
        case (w_d_reg)
            REG_LED:     w_mmio_rdata = {16'h0, r_led};
            REG_SWITCH:  w_mmio_rdata = {24'h0, r_sw_sync};
            REG_TIMER:   w_mmio_rdata = r_timer;
            REG_SCRATCH: w_mmio_rdata = r_scratch;
            default:     w_mmio_rdata = 32'h0;
        endcase
    end

    // NOTE: RAM contents are deliberately not reset; reset only gates the write enable.
    always_ff @(posedge clk) begin
        if (!rst && data_sram_en && !w_d_mmio) begin
            for (int b = 0; b < 4; b++)
                if (data_sram_wen[b]) r_mem[w_d_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
    end

    // NOTE: non-blocking assignments make these reads see the pre-write word (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_rdata <= 32'h0;
            r_data_rdata <= 32'h0;
        end else begin
            if (inst_sram_en)
                r_inst_rdata <= w_i_mmio ? 32'h0 : r_mem[w_i_idx];
            if (data_sram_en)
                r_data_rdata <= w_d_mmio ? w_mmio_rdata : r_mem[w_d_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led     <= 16'h0;
            r_sw_meta <= 8'h0;
            r_sw_sync <= 8'h0;
            r_timer   <= 32'h0;
            r_scratch <= 32'h0;
            r_err     <= 1'b0;
        end else begin
            r_sw_meta <= switch;
            r_sw_sync <= r_sw_meta;
            if (w_d_mmio_acc && w_d_wr && (w_d_reg == REG_LED))
                r_led <= w_led_merged[15:0];
            if (w_d_mmio_acc && w_d_wr && (w_d_reg == REG_TIMER))
                r_timer <= byte_merge(r_timer, data_sram_wdata, data_sram_wen);
            else
                r_timer <= r_timer + 32'd1;
            if (w_d_mmio_acc && w_d_wr && (w_d_reg == REG_SCRATCH))
                r_scratch <= byte_merge(r_scratch, data_sram_wdata, data_sram_wen);
            if (w_i_bad || w_d_bad)
                r_err <= 1'b1;
        end
    end

    assign inst_sram_rdata = r_inst_rdata;
    assign data_sram_rdata = r_data_rdata;
    assign led             = r_led;
    assign err             = r_err;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: a per-cycle vector table plus hand-written
// sequences for reset, timer wrap, switch synchronizer and sticky error behaviour.
`timescale 1ns/1ps
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] led;
    logic [7:0]  switch;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    sram_responder dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .led             (led),
        .switch          (switch),
        .err             (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        d_en;
        logic [3:0]  d_wen;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        i_en;
        logic [31:0] i_addr;
        logic        chk_d;
        logic [31:0] exp_d;
        logic        chk_i;
        logic [31:0] exp_i;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_sram_en    = 1'b0;
        inst_sram_wen   = 4'h0;
        inst_sram_addr  = 32'h0;
        inst_sram_wdata = 32'h0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
    endtask

    task automatic d_req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
    endtask

    task automatic i_req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        inst_sram_en    = 1'b1;
        inst_sram_wen   = wen;
        inst_sram_addr  = addr;
        inst_sram_wdata = wdata;
    endtask

    initial begin
        rst    = 1'b1;
        switch = 8'h00;
        idle();

        // Requests during reset must be ignored, including an illegal inst write.
        d_req(4'hF, 32'h1FAF_0000, 32'hFFFF_FFFF);
        i_req(4'hF, 32'h1FAF_0000, 32'h1);
        cyc();
        cyc();
        check("rst_inst_rdata", inst_sram_rdata, 32'h0);
        check("rst_data_rdata", data_sram_rdata, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);

        // TIMER reads 0 in the first cycle after reset, then 1.
        rst = 1'b0;
        idle();
        d_req(4'h0, 32'h1FAF_0008, 32'h0);
        cyc();
        check("timer_first", data_sram_rdata, 32'h0);
        cyc();
        check("timer_second", data_sram_rdata, 32'h1);

        //              d_en wen    d_addr         d_wdata        i_en i_addr        chk_d exp_d          chk_i exp_i          led
        vecs.push_back('{1, 4'hF, 32'hBFC0_0010, 32'h1234_5678, 0, 32'h0,          0, 32'h0,          0, 32'h0,          16'h0000});
        vecs.push_back('{1, 4'h0, 32'h1FC0_0010, 32'h0,         1, 32'h1FC0_0010,  1, 32'h1234_5678,  1, 32'h1234_5678,  16'h0000});
        vecs.push_back('{0, 4'h0, 32'h0,         32'h0,         0, 32'h0,          1, 32'h1234_5678,  1, 32'h1234_5678,  16'h0000});
        vecs.push_back('{1, 4'hF, 32'h0000_0020, 32'hAABB_CCDD, 0, 32'h0,          0, 32'h0,          0, 32'h0,          16'h0000});
        vecs.push_back('{1, 4'h5, 32'h0000_0020, 32'h1122_3344, 0, 32'h0,          1, 32'hAABB_CCDD,  0, 32'h0,          16'h0000});
        vecs.push_back('{1, 4'h0, 32'h0000_0020, 32'h0,         1, 32'h8000_0020,  1, 32'hAA22_CC44,  1, 32'hAA22_CC44,  16'h0000});
        vecs.push_back('{1, 4'h0, 32'h0001_0020, 32'h0,         0, 32'h0,          1, 32'hAA22_CC44,  1, 32'hAA22_CC44,  16'h0000});
        vecs.push_back('{1, 4'hF, 32'h0000_0030, 32'h0000_0005, 0, 32'h0,          0, 32'h0,          0, 32'h0,          16'h0000});
        vecs.push_back('{1, 4'hF, 32'h0000_0030, 32'h0,         1, 32'h0000_0030,  1, 32'h0000_0005,  1, 32'h0000_0005,  16'h0000});
        vecs.push_back('{0, 4'h0, 32'h0,         32'h0,         1, 32'h0000_0030,  1, 32'h0000_0005,  1, 32'h0,          16'h0000});
        vecs.push_back('{1, 4'hF, 32'h1FAF_0000, 32'hFFFF_1234, 0, 32'h0,          1, 32'h0,          0, 32'h0,          16'h1234});
        vecs.push_back('{1, 4'h0, 32'h1FAF_0000, 32'h0,         0, 32'h0,          1, 32'h0000_1234,  0, 32'h0,          16'h1234});
        vecs.push_back('{1, 4'h2, 32'h1FAF_0001, 32'h0000_AB00, 0, 32'h0,          1, 32'h0000_1234,  0, 32'h0,          16'hAB34});
        vecs.push_back('{1, 4'h0, 32'hBFAF_0000, 32'h0,         0, 32'h0,          1, 32'h0000_AB34,  0, 32'h0,          16'hAB34});
        vecs.push_back('{1, 4'hF, 32'h1FAF_000C, 32'h600D_F00D, 0, 32'h0,          1, 32'h0,          0, 32'h0,          16'hAB34});
        vecs.push_back('{1, 4'h8, 32'h1FAF_000C, 32'h9900_0000, 0, 32'h0,          1, 32'h600D_F00D,  0, 32'h0,          16'hAB34});
        vecs.push_back('{1, 4'h0, 32'h1FAF_000C, 32'h0,         0, 32'h0,          1, 32'h990D_F00D,  0, 32'h0,          16'hAB34});
        vecs.push_back('{1, 4'hF, 32'h1FAF_0004, 32'hFFFF_FFFF, 0, 32'h0,          1, 32'h0,          0, 32'h0,          16'hAB34});
        vecs.push_back('{1, 4'h0, 32'h1FAF_0004, 32'h0,         0, 32'h0,          1, 32'h0,          0, 32'h0,          16'hAB34});
        vecs.push_back('{1, 4'hF, 32'h1FAE_FFFC, 32'h0BAD_C0DE, 0, 32'h0,          0, 32'h0,          0, 32'h0,          16'hAB34});
        vecs.push_back('{1, 4'h0, 32'h0000_FFFC, 32'h0,         0, 32'h0,          1, 32'h0BAD_C0DE,  0, 32'h0,          16'hAB34});
        vecs.push_back('{1, 4'hF, 32'h1FB0_0000, 32'hFEED_BEEF, 0, 32'h0,          0, 32'h0,          0, 32'h0,          16'hAB34});
        vecs.push_back('{1, 4'h0, 32'h0000_0000, 32'h0,         1, 32'h0000_0000,  1, 32'hFEED_BEEF,  1, 32'hFEED_BEEF,  16'hAB34});

        for (int k = 0; k < vecs.size(); k++) begin
            idle();
            if (vecs[k].d_en) d_req(vecs[k].d_wen, vecs[k].d_addr, vecs[k].d_wdata);
            if (vecs[k].i_en) i_req(4'h0, vecs[k].i_addr, 32'h0);
            cyc();
            if (vecs[k].chk_d) check($sformatf("vec%0d_data", k), data_sram_rdata, vecs[k].exp_d);
            if (vecs[k].chk_i) check($sformatf("vec%0d_inst", k), inst_sram_rdata, vecs[k].exp_i);
            check($sformatf("vec%0d_led", k), {16'h0, led}, {16'h0, vecs[k].exp_led});
            check($sformatf("vec%0d_err", k), {31'h0, err}, 32'h0);
        end

        // TIMER wrap, then a single-byte load.
        idle();
        d_req(4'hF, 32'h1FAF_0008, 32'hFFFF_FFFE);
        cyc();
        d_req(4'h0, 32'h1FAF_0008, 32'h0);
        cyc();
        check("timer_wrap0", data_sram_rdata, 32'hFFFF_FFFE);
        cyc();
        check("timer_wrap1", data_sram_rdata, 32'hFFFF_FFFF);
        cyc();
        check("timer_wrap2", data_sram_rdata, 32'h0);
        d_req(4'h1, 32'h1FAF_0008, 32'h0000_00AA);
        cyc();
        check("timer_bytewr_old", data_sram_rdata, 32'h1);
        d_req(4'h0, 32'h1FAF_0008, 32'h0);
        cyc();
        check("timer_bytewr_new", data_sram_rdata, 32'h0000_00AA);

        // Two-flop switch synchronizer.
        idle();
        switch = 8'hA5;
        cyc();
        d_req(4'h0, 32'h1FAF_0004, 32'h0);
        cyc();
        check("switch_one_stage", data_sram_rdata, 32'h0);
        cyc();
        check("switch_synced", data_sram_rdata, 32'h0000_00A5);

        // Unmapped MMIO offset: reads 0, err sticks.
        d_req(4'h0, 32'h1FAF_0010, 32'h0);
        cyc();
        check("bad_off_rdata", data_sram_rdata, 32'h0);
        check("bad_off_err", {31'h0, err}, 32'h1);
        idle();
        cyc();
        cyc();
        check("err_sticky", {31'h0, err}, 32'h1);

        // Reset mid-operation cancels the write; RAM keeps its contents.
        d_req(4'hF, 32'h0000_0200, 32'hCAFE_F00D);
        cyc();
        rst = 1'b1;
        d_req(4'hF, 32'h0000_0200, 32'h0);
        i_req(4'h0, 32'h0000_0200, 32'h0);
        cyc();
        check("midrst_data", data_sram_rdata, 32'h0);
        check("midrst_inst", inst_sram_rdata, 32'h0);
        check("midrst_led", {16'h0, led}, 32'h0);
        check("midrst_err", {31'h0, err}, 32'h0);
        rst = 1'b0;
        d_req(4'h0, 32'h0000_0200, 32'h0);
        i_req(4'h0, 32'h0000_0200, 32'h0);
        cyc();
        check("rst_cancel_data", data_sram_rdata, 32'hCAFE_F00D);
        check("rst_cancel_inst", inst_sram_rdata, 32'hCAFE_F00D);
        idle();
        d_req(4'h0, 32'h1FAF_000C, 32'h0);
        cyc();
        check("scratch_after_rst", data_sram_rdata, 32'h0);

        // Instruction-port write attempt: read only, err set.
        idle();
        d_req(4'hF, 32'h0000_0040, 32'h0000_0077);
        cyc();
        idle();
        i_req(4'hF, 32'h0000_0040, 32'h0000_0099);
        cyc();
        check("iwr_rdata", inst_sram_rdata, 32'h0000_0077);
        check("iwr_err", {31'h0, err}, 32'h1);
        idle();
        d_req(4'h0, 32'h0000_0040, 32'h0);
        cyc();
        check("iwr_no_write", data_sram_rdata, 32'h0000_0077);
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("err_cleared1", {31'h0, err}, 32'h0);

        // Instruction read of MMIO returns 0 and sets err.
        d_req(4'hF, 32'h1FAF_0000, 32'h0000_5A5A);
        i_req(4'h0, 32'h0000_0040, 32'h0);
        cyc();
        check("iram_before_mmio", inst_sram_rdata, 32'h0000_0077);
        idle();
        i_req(4'h0, 32'h1FAF_0000, 32'h0);
        cyc();
        check("immio_rdata", inst_sram_rdata, 32'h0);
        check("immio_err", {31'h0, err}, 32'h1);
        check("immio_led", {16'h0, led}, 32'h0000_5A5A);
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("err_cleared2", {31'h0, err}, 32'h0);

        // Last word of the MMIO window is an unmapped offset.
        d_req(4'h0, 32'h0000_0040, 32'h0);
        cyc();
        check("pre_top_read", data_sram_rdata, 32'h0000_0077);
        d_req(4'hF, 32'h1FAF_FFFC, 32'h1234_5678);
        cyc();
        check("top_off_rdata", data_sram_rdata, 32'h0);
        check("top_off_err", {31'h0, err}, 32'h1);

        idle();
        cyc();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
